// File: rtl/vsetvl_unit_pkg.sv
// Shared definitions for the vsetvl configuration unit: vtype field layout,
// SEW/LMUL encodings, and the request FSM state type.
package vsetvl_unit_pkg;

   // vtype field positions: {vill, lmul_enc[2:0], sew_enc[2:0]}
   localparam int VILL_BIT = 6;
   localparam int LMUL_MSB = 5;
   localparam int LMUL_LSB = 3;
   localparam int SEW_MSB  = 2;
   localparam int SEW_LSB  = 0;

   // Value committed to vtype whenever the configuration is illegal
   localparam logic [6:0] VTYPE_ILLEGAL = 7'h40;

   // SEW encodings
   localparam logic [2:0] SEW_ENC_4  = 3'b000;
   localparam logic [2:0] SEW_ENC_8  = 3'b001;
   localparam logic [2:0] SEW_ENC_16 = 3'b010;
   localparam logic [2:0] SEW_ENC_32 = 3'b011;
   localparam logic [2:0] SEW_ENC_64 = 3'b100;

   // LMUL encodings
   localparam logic [2:0] LMUL_ENC_1  = 3'b000;
   localparam logic [2:0] LMUL_ENC_2  = 3'b001;
   localparam logic [2:0] LMUL_ENC_4  = 3'b010;
   localparam logic [2:0] LMUL_ENC_8  = 3'b011;
   localparam logic [2:0] LMUL_ENC_16 = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Assemble a legal vtype word from its encoded fields
   function automatic logic [6:0] pack_vtype(input logic [2:0] lmul_enc,
                                             input logic [2:0] sew_enc);
      return {1'b0, lmul_enc, sew_enc};
   endfunction

endpackage

// File: rtl/vsetvl_unit_vtype_encoder.sv
// Combinational numeric SEW/LMUL to vtype-field encoder; the inverse of the
// vtype decoder. Unsupported values clear the matching valid flag.
module vtype_encoder
   import vsetvl_unit_pkg::*;
(
   input  logic [6:0] sew,
   input  logic [4:0] lmul,
   output logic [2:0] sew_enc,
   output logic       sew_ok,
   output logic [2:0] lmul_enc,
   output logic       lmul_ok
);

   // Map numeric SEW to its 3-bit encoding
   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      sew_enc = SEW_ENC_4;
      sew_ok  = 1'b1;
      case (sew)
         7'd4:    sew_enc = SEW_ENC_4;
         7'd8:    sew_enc = SEW_ENC_8;
         7'd16:   sew_enc = SEW_ENC_16;
         7'd32:   sew_enc = SEW_ENC_32;
         7'd64:   sew_enc = SEW_ENC_64;
         default: sew_ok  = 1'b0;
      endcase
   end

   // Map numeric LMUL to its 3-bit encoding
   always_comb begin
      lmul_enc = LMUL_ENC_1;
      lmul_ok  = 1'b1;
      case (lmul)
         5'd1:    lmul_enc = LMUL_ENC_1;
         5'd2:    lmul_enc = LMUL_ENC_2;
         5'd4:    lmul_enc = LMUL_ENC_4;
         5'd8:    lmul_enc = LMUL_ENC_8;
         5'd16:   lmul_enc = LMUL_ENC_16;
         default: lmul_ok  = 1'b0;
      endcase
   end

endmodule

// File: rtl/vsetvl_unit.sv
// vsetvl execution unit: latches a request, encodes vtype, computes VLMAX
// and the granted vl, and commits vtype/vl on the response handshake.
module vsetvl_unit
   import vsetvl_unit_pkg::*;
#(
   parameter int VLEN = 128,
   parameter int XLEN = 32,
   parameter int VL_W = $clog2(VLEN*4)+1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [6:0]      req_sew,
   input  logic [4:0]      req_lmul,
   input  logic [XLEN-1:0] req_avl,
   input  logic            req_avl_max,
   input  logic            req_keep_vl,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [VL_W-1:0] rsp_vl,
   output logic            rsp_vill,
   output logic [6:0]      csr_vtype,
   output logic [VL_W-1:0] csr_vl
);

   // VLEN << 4 exceeds VL_W bits before the SEW shift brings it back in range,
   // so the shift chain runs four bits wider and the result is then narrowed.
   localparam int WIDE_W = VL_W + 4;
   localparam int CMP_W  = (XLEN > VL_W) ? XLEN : VL_W;

   state_t            state, next_state;

   logic [6:0]        lat_sew;
   logic [4:0]        lat_lmul;
   logic [XLEN-1:0]   lat_avl;
   logic              lat_avl_max;
   logic              lat_keep_vl;

   logic [2:0]        sew_enc, lmul_enc;
   logic              sew_ok, lmul_ok;

   logic [WIDE_W-1:0] vlmax_wide;
   logic [VL_W-1:0]   vlmax;
   logic [CMP_W-1:0]  avl_cmp, vlmax_cmp;
   logic              calc_vill;
   logic [VL_W-1:0]   calc_vl;
   logic [6:0]        calc_vtype;
   logic [6:0]        rsp_vtype;

   vtype_encoder u_encoder (
      .sew      (lat_sew),
      .lmul     (lat_lmul),
      .sew_enc  (sew_enc),
      .sew_ok   (sew_ok),
      .lmul_enc (lmul_enc),
      .lmul_ok  (lmul_ok)
   );

   assign vlmax_wide = (WIDE_W'(VLEN) << lmul_enc) >> ({1'b0, sew_enc} + 4'd2);
   assign vlmax      = vlmax_wide[VL_W-1:0];
   assign avl_cmp    = CMP_W'(lat_avl);
   assign vlmax_cmp  = CMP_W'(vlmax);

   // Select the granted vl in priority order: illegal, AVL=max, keep, min
   always_comb begin
      calc_vill = !(sew_ok && lmul_ok);
      calc_vl   = '0;
      if (calc_vill) begin
         calc_vl = '0;
      end else if (lat_avl_max) begin
         calc_vl = vlmax;
      end else if (lat_keep_vl) begin
         if (csr_vl <= vlmax) begin
            calc_vl = csr_vl;
         end else begin
            calc_vill = 1'b1;
         end
      end else if (avl_cmp < vlmax_cmp) begin
         calc_vl = avl_cmp[VL_W-1:0];
      end else begin
         calc_vl = vlmax;
      end
      calc_vtype = calc_vill ? VTYPE_ILLEGAL : pack_vtype(lmul_enc, sew_enc);
   end

   // FSM state register
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= next_state;
   end

   // Next-state logic; flush aborts CALC/RESP and beats a same-cycle rsp_ready
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: if (req_valid)            next_state = ST_CALC;
         ST_CALC: next_state = flush ? ST_IDLE : ST_RESP;
         ST_RESP: if (flush || rsp_ready)   next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   assign req_ready = (state == ST_IDLE);
   assign rsp_valid = (state == ST_RESP);

   // Request latch, result registers and architectural CSRs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_sew     <= '0;
         lat_lmul    <= '0;
         lat_avl     <= '0;
         lat_avl_max <= 1'b0;
         lat_keep_vl <= 1'b0;
         rsp_vl      <= '0;
         rsp_vill    <= 1'b0;
         rsp_vtype   <= VTYPE_ILLEGAL;
         csr_vtype   <= VTYPE_ILLEGAL;
         csr_vl      <= '0;
      end else begin
         case (state)
            ST_IDLE: if (req_valid) begin
               lat_sew     <= req_sew;
               lat_lmul    <= req_lmul;
               lat_avl     <= req_avl;
               lat_avl_max <= req_avl_max;
               lat_keep_vl <= req_keep_vl;
            end
            ST_CALC: if (!flush) begin
               rsp_vl    <= calc_vl;
               rsp_vill  <= calc_vill;
               rsp_vtype <= calc_vtype;
            end
            ST_RESP: if (rsp_ready && !flush) begin
               csr_vtype <= rsp_vtype;
               csr_vl    <= rsp_vl;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_vsetvl_unit.sv
// Directed testbench for vsetvl_unit with hand-computed expected values.
module tb_vsetvl_unit;

   localparam int VLEN = 128;
   localparam int XLEN = 32;
   localparam int VL_W = 10;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            flush = 1'b0;
   logic            req_valid = 1'b0;
   logic            req_ready;
   logic [6:0]      req_sew = '0;
   logic [4:0]      req_lmul = '0;
   logic [XLEN-1:0] req_avl = '0;
   logic            req_avl_max = 1'b0;
   logic            req_keep_vl = 1'b0;
   logic            rsp_valid;
   logic            rsp_ready = 1'b0;
   logic [VL_W-1:0] rsp_vl;
   logic            rsp_vill;
   logic [6:0]      csr_vtype;
   logic [VL_W-1:0] csr_vl;

   int n_checks = 0;
   int n_fail   = 0;

   logic [VL_W-1:0] got_vl;
   logic            got_vill;

   vsetvl_unit #(.VLEN(VLEN), .XLEN(XLEN), .VL_W(VL_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_sew     (req_sew),
      .req_lmul    (req_lmul),
      .req_avl     (req_avl),
      .req_avl_max (req_avl_max),
      .req_keep_vl (req_keep_vl),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_vl      (rsp_vl),
      .rsp_vill    (rsp_vill),
      .csr_vtype   (csr_vtype),
      .csr_vl      (csr_vl)
   );

   always #5 clk = ~clk;

   // Drive one request at the current negedge; returns at the negedge after acceptance
   task automatic issue(input logic [6:0] sew, input logic [4:0] lmul,
                        input logic [31:0] avl, input logic amax, input logic keep);
      req_sew = sew; req_lmul = lmul; req_avl = avl;
      req_avl_max = amax; req_keep_vl = keep; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0; req_avl_max = 1'b0; req_keep_vl = 1'b0;
   endtask

   // Bounded wait for rsp_valid
   task automatic wait_rsp(input string name);
      int cyc = 0;
      while (!rsp_valid && cyc < 8) begin
         @(negedge clk);
         cyc++;
      end
      n_checks++;
      if (rsp_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL %s rsp_valid timeout: got %b required 1", name, rsp_valid);
      end
   endtask

   task automatic commit();
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   // Complete request/response/commit; returns the response fields
   task automatic run_op(input string name, input logic [6:0] sew, input logic [4:0] lmul,
                         input logic [31:0] avl, input logic amax, input logic keep,
                         output logic [VL_W-1:0] vl, output logic vill);
      issue(sew, lmul, avl, amax, keep);
      wait_rsp(name);
      vl   = rsp_vl;
      vill = rsp_vill;
      commit();
   endtask

   task automatic test_reset();
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset req_ready: got %b required 1", req_ready); end
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset rsp_valid: got %b required 0", rsp_valid); end
      n_checks++; if (rsp_vl !== 10'd0) begin n_fail++; $display("FAIL reset rsp_vl: got %0d required 0", rsp_vl); end
      n_checks++; if (rsp_vill !== 1'b0) begin n_fail++; $display("FAIL reset rsp_vill: got %b required 0", rsp_vill); end
      n_checks++; if (csr_vtype !== 7'h40) begin n_fail++; $display("FAIL reset csr_vtype: got %h required 40", csr_vtype); end
      n_checks++; if (csr_vl !== 10'd0) begin n_fail++; $display("FAIL reset csr_vl: got %0d required 0", csr_vl); end
   endtask

   // sew=32 lmul=1 avl=10: VLMAX=4 -> vl=4, with response latency check
   task automatic test_basic();
      issue(7'd32, 5'd1, 32'd10, 1'b0, 1'b0);
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL basic rsp_valid in CALC: got %b required 0", rsp_valid); end
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL basic req_ready in CALC: got %b required 0", req_ready); end
      @(negedge clk);
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL basic rsp_valid in RESP: got %b required 1", rsp_valid); end
      n_checks++; if (rsp_vl !== 10'd4) begin n_fail++; $display("FAIL basic rsp_vl: got %0d required 4", rsp_vl); end
      n_checks++; if (rsp_vill !== 1'b0) begin n_fail++; $display("FAIL basic rsp_vill: got %b required 0", rsp_vill); end
      n_checks++; if (csr_vl !== 10'd0) begin n_fail++; $display("FAIL basic csr_vl before commit: got %0d required 0", csr_vl); end
      commit();
      n_checks++; if (csr_vtype !== 7'h03) begin n_fail++; $display("FAIL basic csr_vtype: got %h required 03", csr_vtype); end
      n_checks++; if (csr_vl !== 10'd4) begin n_fail++; $display("FAIL basic csr_vl: got %0d required 4", csr_vl); end
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL basic rsp_valid after commit: got %b required 0", rsp_valid); end
   endtask

   // sew=8 lmul=4: VLMAX=64; AVL below, equal to and above VLMAX
   task automatic test_min_avl();
      run_op("min20", 7'd8, 5'd4, 32'd20, 1'b0, 1'b0, got_vl, got_vill);
      n_checks++; if (got_vl !== 10'd20) begin n_fail++; $display("FAIL min20 rsp_vl: got %0d required 20", got_vl); end
      n_checks++; if (csr_vtype !== 7'h11) begin n_fail++; $display("FAIL min20 csr_vtype: got %h required 11", csr_vtype); end
      run_op("min64", 7'd8, 5'd4, 32'd64, 1'b0, 1'b0, got_vl, got_vill);
      n_checks++; if (got_vl !== 10'd64) begin n_fail++; $display("FAIL min64 rsp_vl: got %0d required 64", got_vl); end
      run_op("minbig", 7'd8, 5'd4, 32'h8000_0004, 1'b0, 1'b0, got_vl, got_vill);
      n_checks++; if (got_vl !== 10'd64) begin n_fail++; $display("FAIL minbig rsp_vl: got %0d required 64", got_vl); end
      n_checks++; if (csr_vl !== 10'd64) begin n_fail++; $display("FAIL minbig csr_vl: got %0d required 64", csr_vl); end
   endtask

   // Next request issued the cycle after commit
   task automatic test_back_to_back();
      run_op("b2b_a", 7'd16, 5'd1, 32'd3, 1'b0, 1'b0, got_vl, got_vill);
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b req_ready after commit: got %b required 1", req_ready); end
      n_checks++; if (got_vl !== 10'd3) begin n_fail++; $display("FAIL b2b_a rsp_vl: got %0d required 3", got_vl); end
      run_op("b2b_b", 7'd64, 5'd2, 32'd9, 1'b0, 1'b0, got_vl, got_vill);
      n_checks++; if (got_vl !== 10'd4) begin n_fail++; $display("FAIL b2b_b rsp_vl: got %0d required 4", got_vl); end
      n_checks++; if (csr_vtype !== 7'h0C) begin n_fail++; $display("FAIL b2b_b csr_vtype: got %h required 0c", csr_vtype); end
   endtask

   // keep_vl legal, then avl_max together with keep_vl
   task automatic test_keep_vl();
      run_op("keep_set", 7'd8, 5'd1, 32'd5, 1'b0, 1'b0, got_vl, got_vill);
      n_checks++; if (csr_vtype !== 7'h01) begin n_fail++; $display("FAIL keep_set csr_vtype: got %h required 01", csr_vtype); end
      run_op("keep_ok", 7'd16, 5'd1, 32'd0, 1'b0, 1'b1, got_vl, got_vill);
      n_checks++; if (got_vl !== 10'd5) begin n_fail++; $display("FAIL keep_ok rsp_vl: got %0d required 5", got_vl); end
      n_checks++; if (csr_vtype !== 7'h02) begin n_fail++; $display("FAIL keep_ok csr_vtype: got %h required 02", csr_vtype); end
      run_op("max_wins", 7'd16, 5'd2, 32'd1, 1'b1, 1'b1, got_vl, got_vill);
      n_checks++; if (got_vl !== 10'd16) begin n_fail++; $display("FAIL max_wins rsp_vl: got %0d required 16", got_vl); end
      n_checks++; if (csr_vtype !== 7'h0A) begin n_fail++; $display("FAIL max_wins csr_vtype: got %h required 0a", csr_vtype); end
   endtask

   // Largest VLMAX, then keep_vl that no longer fits
   task automatic test_avl_max_keep();
      run_op("max512", 7'd4, 5'd16, 32'd3, 1'b1, 1'b0, got_vl, got_vill);
      n_checks++; if (got_vl !== 10'd512) begin n_fail++; $display("FAIL max512 rsp_vl: got %0d required 512", got_vl); end
      n_checks++; if (csr_vtype !== 7'h20) begin n_fail++; $display("FAIL max512 csr_vtype: got %h required 20", csr_vtype); end
      n_checks++; if (csr_vl !== 10'd512) begin n_fail++; $display("FAIL max512 csr_vl: got %0d required 512", csr_vl); end
      run_op("keep_bad", 7'd64, 5'd1, 32'd0, 1'b0, 1'b1, got_vl, got_vill);
      n_checks++; if (got_vill !== 1'b1) begin n_fail++; $display("FAIL keep_bad rsp_vill: got %b required 1", got_vill); end
      n_checks++; if (got_vl !== 10'd0) begin n_fail++; $display("FAIL keep_bad rsp_vl: got %0d required 0", got_vl); end
      n_checks++; if (csr_vtype !== 7'h40) begin n_fail++; $display("FAIL keep_bad csr_vtype: got %h required 40", csr_vtype); end
      n_checks++; if (csr_vl !== 10'd0) begin n_fail++; $display("FAIL keep_bad csr_vl: got %0d required 0", csr_vl); end
   endtask

   // Illegal SEW/LMUL values
   task automatic test_illegal();
      run_op("legal_pre", 7'd32, 5'd1, 32'd2, 1'b0, 1'b0, got_vl, got_vill);
      issue(7'd12, 5'd3, 32'd10, 1'b0, 1'b0);
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL illegal req_ready in CALC: got %b required 0", req_ready); end
      wait_rsp("illegal");
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL illegal req_ready in RESP: got %b required 0", req_ready); end
      n_checks++; if (rsp_vill !== 1'b1) begin n_fail++; $display("FAIL illegal rsp_vill: got %b required 1", rsp_vill); end
      n_checks++; if (rsp_vl !== 10'd0) begin n_fail++; $display("FAIL illegal rsp_vl: got %0d required 0", rsp_vl); end
      commit();
      n_checks++; if (csr_vtype !== 7'h40) begin n_fail++; $display("FAIL illegal csr_vtype: got %h required 40", csr_vtype); end
      n_checks++; if (csr_vl !== 10'd0) begin n_fail++; $display("FAIL illegal csr_vl: got %0d required 0", csr_vl); end
   endtask

   // rsp_ready held low three cycles; response held, CSRs untouched
   task automatic test_backpressure();
      issue(7'd16, 5'd8, 32'd100, 1'b0, 1'b0);
      wait_rsp("bp");
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp%0d rsp_valid: got %b required 1", i, rsp_valid); end
         n_checks++; if (rsp_vl !== 10'd64) begin n_fail++; $display("FAIL bp%0d rsp_vl: got %0d required 64", i, rsp_vl); end
         n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp%0d req_ready: got %b required 0", i, req_ready); end
         n_checks++; if (csr_vtype !== 7'h40) begin n_fail++; $display("FAIL bp%0d csr_vtype: got %h required 40", i, csr_vtype); end
         @(negedge clk);
      end
      commit();
      n_checks++; if (csr_vtype !== 7'h1A) begin n_fail++; $display("FAIL bp csr_vtype: got %h required 1a", csr_vtype); end
      n_checks++; if (csr_vl !== 10'd64) begin n_fail++; $display("FAIL bp csr_vl: got %0d required 64", csr_vl); end
   endtask

   // flush in RESP (with same-cycle rsp_ready) and in CALC
   task automatic test_flush();
      issue(7'd32, 5'd2, 32'd3, 1'b0, 1'b0);
      wait_rsp("flush_resp");
      flush = 1'b1; rsp_ready = 1'b1;
      @(negedge clk);
      flush = 1'b0; rsp_ready = 1'b0;
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_resp rsp_valid: got %b required 0", rsp_valid); end
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL flush_resp req_ready: got %b required 1", req_ready); end
      n_checks++; if (csr_vtype !== 7'h1A) begin n_fail++; $display("FAIL flush_resp csr_vtype: got %h required 1a", csr_vtype); end
      n_checks++; if (csr_vl !== 10'd64) begin n_fail++; $display("FAIL flush_resp csr_vl: got %0d required 64", csr_vl); end
      issue(7'd8, 5'd1, 32'd7, 1'b0, 1'b0);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL flush_calc req_ready: got %b required 1", req_ready); end
      @(negedge clk);
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_calc rsp_valid: got %b required 0", rsp_valid); end
      n_checks++; if (csr_vl !== 10'd64) begin n_fail++; $display("FAIL flush_calc csr_vl: got %0d required 64", csr_vl); end
   endtask

   // Asynchronous reset during CALC, then recovery
   task automatic test_reset_mid();
      issue(7'd8, 5'd2, 32'd9, 1'b0, 1'b0);
      rst_n = 1'b0;
      #1;
      n_checks++; if (csr_vtype !== 7'h40) begin n_fail++; $display("FAIL rst_mid csr_vtype: got %h required 40", csr_vtype); end
      n_checks++; if (csr_vl !== 10'd0) begin n_fail++; $display("FAIL rst_mid csr_vl: got %0d required 0", csr_vl); end
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid rsp_valid: got %b required 0", rsp_valid); end
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid req_ready: got %b required 1", req_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid rsp_valid after release: got %b required 0", rsp_valid); end
      run_op("recover", 7'd64, 5'd8, 32'd7, 1'b0, 1'b0, got_vl, got_vill);
      n_checks++; if (got_vl !== 10'd7) begin n_fail++; $display("FAIL recover rsp_vl: got %0d required 7", got_vl); end
      n_checks++; if (csr_vtype !== 7'h1C) begin n_fail++; $display("FAIL recover csr_vtype: got %h required 1c", csr_vtype); end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_basic();
      test_min_avl();
      test_back_to_back();
      test_keep_vl();
      test_avl_max_keep();
      test_illegal();
      test_backpressure();
      test_flush();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
